// File: rtl/multi_blinky_pkg.sv
// Shared types for the multi-channel LED blinker: request modes and
// per-channel FSM states.
package multi_blinky_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STEADY_ON = 2'd1,
    ST_PHASE_ON  = 2'd2,
    ST_PHASE_OFF = 2'd3
  } chan_state_e;

endpackage

// File: rtl/multi_blinky_channel.sv
// One LED channel: steady off/on, endless blink, or a counted burst.
// A load always restarts the pattern from scratch.
module multi_blinky_channel
  import multi_blinky_pkg::*;
#(
  parameter int CounterWidth = 24,
  parameter int BurstWidth   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    i_load,
  input  logic [1:0]              i_mode,
  input  logic [CounterWidth-1:0] i_half_period,
  input  logic [BurstWidth-1:0]   i_burst_count,
  output logic                    o_led,
  output logic                    o_busy
);

  chan_state_e             r_state, w_state_nxt;
  logic [CounterWidth-1:0] r_cnt, w_cnt_nxt;
  logic [CounterWidth-1:0] r_hm1, w_hm1_nxt;
  logic [BurstWidth-1:0]   r_left, w_left_nxt;
  logic                    r_burst, w_burst_nxt;
  logic [CounterWidth-1:0] w_cfg_hm1;
  mode_e                   w_mode;

  // Half-period 0 behaves as 1; storing H-1 keeps H=max inside the counter.
  assign w_cfg_hm1 = (i_half_period == '0) ? '0 : i_half_period - 1'b1;
  assign w_mode    = mode_e'(i_mode);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_hm1   <= '0;
      r_left  <= '0;
      r_burst <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hm1   <= w_hm1_nxt;
      r_left  <= w_left_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hm1_nxt   = r_hm1;
    w_left_nxt  = r_left;
    w_burst_nxt = r_burst;
    if (i_load) begin
      w_cnt_nxt   = '0;
      w_hm1_nxt   = '0;
      w_left_nxt  = '0;
      w_burst_nxt = 1'b0;
      case (w_mode)
        MODE_OFF: w_state_nxt = ST_IDLE;
        MODE_ON:  w_state_nxt = ST_STEADY_ON;
        MODE_BLINK: begin
          w_state_nxt = ST_PHASE_ON;
          w_cnt_nxt   = w_cfg_hm1;
          w_hm1_nxt   = w_cfg_hm1;
        end
        MODE_BURST: begin
          if (i_burst_count == '0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_PHASE_ON;
            w_cnt_nxt   = w_cfg_hm1;
            w_hm1_nxt   = w_cfg_hm1;
            w_left_nxt  = i_burst_count;
            w_burst_nxt = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else begin
      case (r_state)
        ST_PHASE_ON: begin
          if (r_cnt == '0) begin
            w_state_nxt = ST_PHASE_OFF;
            w_cnt_nxt   = r_hm1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        ST_PHASE_OFF: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else if (r_burst && r_left == BurstWidth'(1)) begin
            // Last off-phase of a burst done: park in IDLE.
            w_state_nxt = ST_IDLE;
            w_left_nxt  = '0;
            w_burst_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_PHASE_ON;
            w_cnt_nxt   = r_hm1;
            if (r_burst) w_left_nxt = r_left - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_led  = (r_state == ST_STEADY_ON) || (r_state == ST_PHASE_ON);
    o_busy = r_burst && ((r_state == ST_PHASE_ON) || (r_state == ST_PHASE_OFF));
  end

endmodule

// File: rtl/multi_blinky.sv
// Multi-channel LED blinker top: request decode plus one channel per LED.
// Define MULTI_BLINKY_ACTIVE_LOW_EN for active-low LED outputs.
module multi_blinky
  import multi_blinky_pkg::*;
#(
  parameter int NumChannels  = 4,
  parameter int CounterWidth = 24,
  parameter int BurstWidth   = 8,
  localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_valid_i,
  output logic                    cfg_ready_o,
  input  logic [ChW-1:0]          cfg_channel_i,
  input  logic [1:0]              cfg_mode_i,
  input  logic [CounterWidth-1:0] cfg_half_period_i,
  input  logic [BurstWidth-1:0]   cfg_burst_count_i,
  output logic [NumChannels-1:0]  led_o,
  output logic [NumChannels-1:0]  busy_o
);

  logic                   w_accept;
  logic [NumChannels-1:0] w_load;
  logic [NumChannels-1:0] w_led;

  // Never stalls; only reset holds off requests.
  assign cfg_ready_o = ~rst_i;
  assign w_accept    = cfg_valid_i & cfg_ready_o;

  // Out-of-range channel indices match no instance and are dropped.
  for (genvar g = 0; g < NumChannels; g++) begin : g_ch
    assign w_load[g] = w_accept && (cfg_channel_i == ChW'(g));

    multi_blinky_channel #(
      .CounterWidth(CounterWidth),
      .BurstWidth  (BurstWidth)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_load       (w_load[g]),
      .i_mode       (cfg_mode_i),
      .i_half_period(cfg_half_period_i),
      .i_burst_count(cfg_burst_count_i),
      .o_led        (w_led[g]),
      .o_busy       (busy_o[g])
    );
  end

`ifdef MULTI_BLINKY_ACTIVE_LOW_EN
  assign led_o = ~w_led;
`else
  assign led_o = w_led;
`endif

endmodule

// File: tb/tb_multi_blinky.sv
// Directed + random bench for multi_blinky; expected LED/busy levels come
// from a time-based model (position within the 2H period since acceptance).
module tb_multi_blinky;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int BW  = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_valid_i = 1'b0;
  logic          cfg_ready_o;
  logic [1:0]    cfg_channel_i = '0;
  logic [1:0]    cfg_mode_i = '0;
  logic [CW-1:0] cfg_half_period_i = '0;
  logic [BW-1:0] cfg_burst_count_i = '0;
  logic [NCH-1:0] led_o;
  logic [NCH-1:0] busy_o;

  multi_blinky #(.NumChannels(NCH), .CounterWidth(CW), .BurstWidth(BW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_channel_i(cfg_channel_i), .cfg_mode_i(cfg_mode_i),
    .cfg_half_period_i(cfg_half_period_i), .cfg_burst_count_i(cfg_burst_count_i),
    .led_o(led_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;
  int m_mode [NCH];
  int m_start[NCH];
  int m_h    [NCH];
  int m_n    [NCH];

`ifdef MULTI_BLINKY_ACTIVE_LOW_EN
  localparam logic [NCH-1:0] LED_INV = '1;
`else
  localparam logic [NCH-1:0] LED_INV = '0;
`endif

  function automatic logic mdl_led(int ch);
    int k = cyc - m_start[ch];
    int h = (m_h[ch] == 0) ? 1 : m_h[ch];
    case (m_mode[ch])
      1:       return 1'b1;
      2:       return (k % (2 * h)) < h;
      3:       return (k < 2 * h * m_n[ch]) && ((k % (2 * h)) < h);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mdl_busy(int ch);
    int k = cyc - m_start[ch];
    int h = (m_h[ch] == 0) ? 1 : m_h[ch];
    return (m_mode[ch] == 3) && (k < 2 * h * m_n[ch]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH-1:0] el, eb;
    for (int c = 0; c < NCH; c++) begin
      el[c] = mdl_led(c);
      eb[c] = mdl_busy(c);
    end
    chk({tag, ".led"},   32'(led_o),       32'(el ^ LED_INV));
    chk({tag, ".busy"},  32'(busy_o),      32'(eb));
    chk({tag, ".ready"}, 32'(cfg_ready_o), 32'(!rst_i));
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0; m_start[c] = 0; m_h[c] = 1; m_n[c] = 0;
    end
  endtask

  // One clock: present a request, model acceptance at the edge, check at negedge.
  task automatic step(input logic v, input int ch, input int mode, input int h,
                      input int n, input string tag);
    cfg_valid_i       = v;
    cfg_channel_i     = ch[1:0];
    cfg_mode_i        = mode[1:0];
    cfg_half_period_i = h[CW-1:0];
    cfg_burst_count_i = n[BW-1:0];
    @(posedge clk_i);
    cyc++;
    if (v && !rst_i) begin
      m_mode[ch] = mode; m_start[ch] = cyc; m_h[ch] = h; m_n[ch] = n;
    end
    @(negedge clk_i);
    cfg_valid_i = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 0, 0, tag);
  endtask

  initial begin
    int rises, busy_cnt;
    logic prev;
    model_reset();

    // Reset state
    #2;
    check_all("reset");
    chk("reset.led_inactive", 32'(led_o), 32'(LED_INV));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Test 1: BLINK ch0 H=5, first request right after reset release
    step(1'b1, 0, 2, 5, 0, "t1.acc");
    idle(44, "t1.run");

    // Test 2: BURST ch2 H=3 N=4
    step(1'b1, 2, 3, 3, 4, "t2.acc");
    rises = 1; busy_cnt = busy_o[2] ? 1 : 0; prev = led_o[2] ^ LED_INV[2];
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 0, 0, 0, 0, "t2.run");
      if ((led_o[2] ^ LED_INV[2]) && !prev) rises++;
      prev = led_o[2] ^ LED_INV[2];
      if (busy_o[2]) busy_cnt++;
    end
    chk("t2.rises", 32'(rises), 32'd4);
    chk("t2.busy_cycles", 32'(busy_cnt), 32'd24);
    chk("t2.led_end", 32'(led_o[2] ^ LED_INV[2]), 32'd0);

    // Test 3: BLINK ch1 H=0 toggles every cycle
    step(1'b1, 1, 2, 0, 0, "t3.acc");
    idle(8, "t3.run");

    // Test 4: BLINK ch3 H=10, ON accepted at cycle 4 of the on-phase
    step(1'b1, 3, 2, 10, 0, "t4.acc");
    idle(3, "t4.on_phase");
    step(1'b1, 3, 1, 0, 0, "t4.on");
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 0, 0, 0, 0, "t4.hold");
      chk("t4.steady", 32'(led_o[3] ^ LED_INV[3]), 32'd1);
    end

    // Burst count 0 parks immediately; max half-period does not wrap
    step(1'b1, 2, 3, 4, 0, "t.burst0");
    step(1'b1, 1, 2, 255, 0, "t.hmax");
    idle(300, "t.hmax_run");

    // Test 5: reset pulsed mid-burst on ch0
    step(1'b1, 0, 3, 3, 5, "t5.acc");
    idle(7, "t5.mid");
    rst_i = 1'b1;
    #1;
    model_reset();
    chk("t5.async_led",   32'(led_o),       32'(LED_INV));
    chk("t5.async_busy",  32'(busy_o),      32'd0);
    chk("t5.async_ready", 32'(cfg_ready_o), 32'd0);
    step(1'b1, 0, 1, 0, 0, "t5.in_reset");
    rst_i = 1'b0;
    #1;
    idle(20, "t5.after");

    // Random requests on all channels
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 15)
        step(1'b1, $urandom_range(0, NCH - 1), $urandom_range(0, 3),
             $urandom_range(0, 6), $urandom_range(0, 4), "rand");
      else
        step(1'b0, 0, 0, 0, 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
